// File: rtl/csr_access_unit.sv
// ============================================================================
// Module   : csr_access_unit
// Purpose  : Sequences CSR read-modify-write instructions (CSRRW/S/C and
//            immediate forms) against a registered-read CSR storage port.
//            Optional macro CSR_RO_CHECK_EN traps writes to read-only CSRs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csr_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_rs1_val,
    input  logic        req_rs1_zero,
    input  logic [4:0]  req_zimm,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    output logic [11:0] csr_rdaddr,
    input  logic [31:0] csr_rdval,
    output logic        csr_write,
    output logic [11:0] csr_wraddr,
    output logic [31:0] csr_wrval
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_MODIFY = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [1:0]  r_op;
    logic [11:0] r_addr;
    logic [31:0] r_src;
    logic        r_srcZero;
    logic [31:0] r_rdata;
    logic        r_illegal;

    logic        w_accept;
    logic        w_funct3Illegal;
    logic        w_writeEn;
    logic        w_roViolation;
    logic        w_doWrite;
    logic [31:0] w_newVal;

    assign w_accept        = req_valid && (r_state == ST_IDLE);
    assign w_funct3Illegal = (req_funct3[1:0] == 2'b00);

    // Set/clear with a zero source is a pure read; plain writes always write.
    assign w_writeEn = (r_op == 2'b01) || !r_srcZero;

`ifdef CSR_RO_CHECK_EN
    assign w_roViolation = w_writeEn && (r_addr[11:10] == 2'b11);
`else
    assign w_roViolation = 1'b0;
`endif

    assign w_doWrite = (r_state == ST_MODIFY) && w_writeEn && !w_roViolation;

    always_comb begin
        w_newVal = csr_rdval;
        case (r_op)
            2'b01:   w_newVal = r_src;
            2'b10:   w_newVal = csr_rdval | r_src;
            2'b11:   w_newVal = csr_rdval & ~r_src;
            default: w_newVal = csr_rdval;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_nextState = w_funct3Illegal ? ST_RESP : ST_READ;
                end
            end
            ST_READ:   w_nextState = ST_MODIFY;
            ST_MODIFY: w_nextState = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op      <= 2'b00;
            r_addr    <= 12'h000;
            r_src     <= 32'h0;
            r_srcZero <= 1'b0;
            r_rdata   <= 32'h0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= req_funct3[1:0];
                r_addr    <= req_addr;
                r_src     <= req_funct3[2] ? {27'b0, req_zimm} : req_rs1_val;
                r_srcZero <= req_funct3[2] ? (req_zimm == 5'd0) : req_rs1_zero;
                r_rdata   <= 32'h0;
                r_illegal <= w_funct3Illegal;
            end else if (r_state == ST_MODIFY) begin
                r_rdata   <= csr_rdval;
                r_illegal <= w_roViolation;
            end
        end
    end

    assign resp_rdata   = r_rdata;
    assign resp_illegal = r_illegal;
    assign csr_rdaddr   = r_addr;
    assign csr_write    = w_doWrite;
    assign csr_wraddr   = w_doWrite ? r_addr : 12'h000;
    assign csr_wrval    = w_doWrite ? w_newVal : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_csr_access_unit.sv
// ============================================================================
// Module   : tb_csr_access_unit
// Purpose  : Self-checking bench for csr_access_unit with a registered-read
//            CSR storage model, directed vectors and a random reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_val;
    logic        req_rs1_zero;
    logic [4:0]  req_zimm;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [11:0] csr_rdaddr;
    logic [31:0] csr_rdval;
    logic        csr_write;
    logic [11:0] csr_wraddr;
    logic [31:0] csr_wrval;

    int nVec  = 0;
    int nFail = 0;

    // CSR storage with registered read and a preload side door for the bench
    logic [31:0] mem    [0:4095];
    logic [31:0] refMem [0:4095];
    logic        preEn  = 1'b0;
    logic [11:0] preAddr = 12'h0;
    logic [31:0] preVal  = 32'h0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        csr_rdval <= mem[csr_rdaddr];
        if (preEn) begin
            mem[preAddr] <= preVal;
        end else if (csr_write) begin
            mem[csr_wraddr] <= csr_wrval;
        end
    end

    csr_access_unit dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_rs1_val (req_rs1_val),
        .req_rs1_zero(req_rs1_zero),
        .req_zimm    (req_zimm),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_illegal(resp_illegal),
        .csr_rdaddr  (csr_rdaddr),
        .csr_rdval   (csr_rdval),
        .csr_write   (csr_write),
        .csr_wraddr  (csr_wraddr),
        .csr_wrval   (csr_wrval)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic        rz;
        logic [4:0]  zimm;
        logic [31:0] pre;
        logic [31:0] eRd;
        logic        eIll;
        logic        eWr;
        logic [31:0] eVal;
        int          eLat;
        int          hold;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        @(negedge clk);
        preEn   = 1'b1;
        preAddr = a;
        preVal  = v;
        @(negedge clk);
        preEn   = 1'b0;
    endtask

    // Reference behaviour straight from the instruction semantics
    function automatic void model(input logic [2:0] f3, input logic [11:0] addr,
                                  input logic [31:0] rs1, input logic rz,
                                  input logic [4:0] zimm, input logic [31:0] old,
                                  output logic [31:0] eRd, output logic eIll,
                                  output logic eWr, output logic [31:0] eVal,
                                  output int eLat);
        logic [31:0] src;
        src  = f3[2] ? {27'b0, zimm} : rs1;
        eVal = 32'h0;
        if (f3 == 3'b000 || f3 == 3'b100) begin
            eRd = 32'h0; eIll = 1'b1; eWr = 1'b0; eLat = 1;
        end else begin
            eRd  = old;
            eIll = 1'b0;
            eLat = 3;
            if (f3[1:0] == 2'b01) begin
                eWr = 1'b1; eVal = src;
            end else if (f3[1:0] == 2'b10) begin
                eWr = (src != 0) && !(f3[2] == 1'b0 && rz); eVal = old | src;
            end else begin
                eWr = (src != 0) && !(f3[2] == 1'b0 && rz); eVal = old & ~src;
            end
            if (f3[2] == 1'b1) eWr = (f3[1:0] == 2'b01) || (zimm != 0);
            else if (rz && f3[1:0] != 2'b01) eWr = 1'b0;
            else if (f3[1:0] != 2'b01) eWr = 1'b1;
`ifdef CSR_RO_CHECK_EN
            if (eWr && addr[11:10] == 2'b11) begin
                eWr = 1'b0; eIll = 1'b1;
            end
`else
            if (addr == 12'hFFF) eLat = 3;
`endif
        end
    endfunction

    task automatic txn(input vec_t v, input logic [31:0] old);
        int          k;
        int          wrSeen;
        int          wrCyc;
        logic [11:0] wrA;
        logic [31:0] wrV;
        logic        got;
        logic        rdyBad;
        logic        holdBad;
        logic [31:0] rd0;
        logic        il0;
        k = 1; wrSeen = 0; wrCyc = 0; wrA = 0; wrV = 0;
        got = 0; rdyBad = 0; holdBad = 0;
        @(negedge clk);
        check("req_ready before accept", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_funct3   = v.f3;
        req_addr     = v.addr;
        req_rs1_val  = v.rs1;
        req_rs1_zero = v.rz;
        req_zimm     = v.zimm;
        @(negedge clk);
        // A competing write request is held up while busy; it must be ignored
        req_funct3   = 3'b001;
        req_addr     = ~v.addr;
        req_rs1_val  = ~v.rs1;
        req_rs1_zero = 1'b0;
        req_zimm     = ~v.zimm;
        while (k <= 8 && !got) begin
            if (csr_write) begin
                wrSeen++; wrCyc = k; wrA = csr_wraddr; wrV = csr_wrval;
            end
            if (req_ready) rdyBad = 1'b1;
            if (resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("resp_valid seen", 32'(got), 32'd1);
        check("latency", 32'(k), 32'(v.eLat));
        check("resp_rdata", resp_rdata, v.eRd);
        check("resp_illegal", 32'(resp_illegal), 32'(v.eIll));
        check("write count", 32'(wrSeen), v.eWr ? 32'd1 : 32'd0);
        check("req_ready busy", 32'(rdyBad), 32'd0);
        if (v.eWr) begin
            check("write cycle", 32'(wrCyc), 32'd2);
            check("csr_wraddr", 32'(wrA), 32'(v.addr));
            check("csr_wrval", wrV, v.eVal);
        end
        rd0 = resp_rdata;
        il0 = resp_illegal;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd0 || resp_illegal !== il0 ||
                req_ready || csr_write) holdBad = 1'b1;
        end
        if (v.hold > 0) check("stall stable", 32'(holdBad), 32'd0);
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        check("idle after handshake", {30'b0, resp_valid, req_ready}, 32'd1);
        check("storage", mem[v.addr], v.eWr ? v.eVal : old);
    endtask

    vec_t        vecs [10];
    vec_t        rv;
    logic [11:0] pool [8];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_funct3 = 3'b0; req_addr = 12'h0;
        req_rs1_val = 32'h0; req_rs1_zero = 1'b0; req_zimm = 5'h0; resp_ready = 1'b0;
        #12;
        check("reset outputs", {28'b0, req_ready, resp_valid, resp_illegal, csr_write}, 32'h8);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset addrs", {8'b0, csr_rdaddr, csr_wraddr}, 32'h0);
        check("reset wrval", csr_wrval, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        //             f3     addr    rs1           rz    zimm   pre           eRd           eIll  eWr   eVal          lat hold
        vecs[0] = '{3'b010, 12'h340, 32'h0000_000F, 1'b0, 5'h00, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 1'b1, 32'h0000_00FF, 3, 0};
        vecs[1] = '{3'b111, 12'h340, 32'hFFFF_FFFF, 1'b0, 5'h0F, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00F0, 3, 5};
        vecs[2] = '{3'b110, 12'h340, 32'hFFFF_FFFF, 1'b0, 5'h00, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 1'b0, 32'h0,         3, 1};
        vecs[3] = '{3'b100, 12'h340, 32'h1234_5678, 1'b0, 5'h1F, 32'h0000_00F0, 32'h0,         1'b1, 1'b0, 32'h0,         1, 0};
        vecs[4] = '{3'b000, 12'h341, 32'h1234_5678, 1'b0, 5'h1F, 32'h0000_0042, 32'h0,         1'b1, 1'b0, 32'h0,         1, 2};
`ifdef CSR_RO_CHECK_EN
        vecs[5] = '{3'b001, 12'hC00, 32'hDEAD_BEEF, 1'b0, 5'h00, 32'h0000_1111, 32'h0000_1111, 1'b1, 1'b0, 32'h0,         3, 0};
`else
        vecs[5] = '{3'b001, 12'hC00, 32'hDEAD_BEEF, 1'b0, 5'h00, 32'h0000_1111, 32'h0000_1111, 1'b0, 1'b1, 32'hDEAD_BEEF, 3, 0};
`endif
        vecs[6] = '{3'b010, 12'h300, 32'h0000_FFFF, 1'b1, 5'h00, 32'h0000_0008, 32'h0000_0008, 1'b0, 1'b0, 32'h0,         3, 0};
        vecs[7] = '{3'b011, 12'h341, 32'h0000_F0F0, 1'b0, 5'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_0F0F, 3, 0};
        vecs[8] = '{3'b101, 12'h342, 32'hFFFF_FFFF, 1'b0, 5'h00, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b1, 32'h0,         3, 0};
        vecs[9] = '{3'b010, 12'hC01, 32'h0000_0000, 1'b1, 5'h00, 32'h0000_0077, 32'h0000_0077, 1'b0, 1'b0, 32'h0,         3, 0};

        for (int i = 0; i < 10; i++) begin
            preload(vecs[i].addr, vecs[i].pre);
            txn(vecs[i], vecs[i].pre);
        end

        // Reset landing in MODIFY of CSRRW 0x305 <= 0x1234 must abort cleanly
        preload(12'h305, 32'hAAAA_0000);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b001; req_addr = 12'h305;
        req_rs1_val = 32'h1234; req_rs1_zero = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("write before abort", 32'(csr_write), 32'd1);
        check("wrval before abort", csr_wrval, 32'h0000_1234);
        #2 reset = 1'b1;
        #1;
        check("abort outputs", {28'b0, req_ready, resp_valid, resp_illegal, csr_write}, 32'h8);
        check("abort wr port", {8'b0, csr_wraddr, csr_rdaddr}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("no resp after abort", {30'b0, resp_valid, req_ready}, 32'd1);
        check("csr unchanged after abort", mem[12'h305], 32'hAAAA_0000);

        pool = '{12'h340, 12'h341, 12'h305, 12'h300, 12'hC00, 12'hC80, 12'hF11, 12'h7C0};
        for (int i = 0; i < 8; i++) begin
            refMem[pool[i]] = $urandom;
            preload(pool[i], refMem[pool[i]]);
        end
        for (int n = 0; n < 150; n++) begin
            rv.f3   = 3'($urandom_range(0, 7));
            rv.addr = pool[$urandom_range(0, 7)];
            rv.rs1  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rv.rz   = ($urandom_range(0, 3) == 0);
            rv.zimm = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom_range(1, 31));
            rv.pre  = refMem[rv.addr];
            rv.hold = $urandom_range(0, 2);
            model(rv.f3, rv.addr, rv.rs1, rv.rz, rv.zimm, rv.pre,
                  rv.eRd, rv.eIll, rv.eWr, rv.eVal, rv.eLat);
            txn(rv, rv.pre);
            if (rv.eWr) refMem[rv.addr] = rv.eVal;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset, with ports:
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 req_valid  in  1  CSR instruction request present.
REQ-005 req_ready  out  1  unit accepts a request; high only in IDLE.
REQ-006 req_funct3  in  3  001 CSRRW, 010 CSRRS, 011 CSRRC, 101 CSRRWI, 110 CSRRSI, 111 CSRRCI.
REQ-007 req_addr  in  12  CSR address.
REQ-008 req_rs1_val  in  32  rs1 operand.
REQ-009 req_rs1_zero  in  1  rs1 field is x0.
REQ-010 req_zimm  in  5  immediate operand.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  consumer takes response.
REQ-013 resp_rdata  out  32  old CSR value (rd writeback).
REQ-014 resp_illegal  out  1  illegal-instruction flag.
REQ-015 csr_rdaddr  out  12  to CSR storage read port; storage returns registered data one cycle later.
REQ-016 csr_rdval  in  32  CSR storage read data.
REQ-017 csr_write, csr_wraddr, csr_wrval  out  1/12/32  CSR storage write port, sampled on clk.

Function
REQ-018 FSM states SHALL be IDLE, READ, MODIFY, RESP.
REQ-019 IDLE: req_valid&&req_ready latches funct3/addr/operands; next READ, or RESP directly with resp_illegal=1, resp_rdata=0 if funct3 is 000 or 100.
REQ-020 READ: csr_rdaddr SHALL equal latched addr; next MODIFY unconditionally.
REQ-021 MODIFY: csr_rdval captured into resp_rdata; new value computed; csr_write pulsed for exactly this cycle if write enabled; next RESP.
REQ-022 Source operand: rs1_val for funct3[2]=0, {27'b0,zimm} for funct3[2]=1.
REQ-023 New value: W -> src; S -> old|src; C -> old&~src; 32-bit, no carries.
REQ-024 Write enable: always for CSRRW/CSRRWI; for S/C forms suppressed when req_rs1_zero=1 (register form) or zimm==0 (immediate form); read still performed.
REQ-025 RESP: resp_valid=1, resp_rdata/resp_illegal stable until resp_valid&&resp_ready; then IDLE.
REQ-026 Latency: resp_valid SHALL assert 3 cycles after acceptance edge for legal requests, 1 cycle for illegal funct3.
REQ-027 Throughput: at most one request in flight; req_ready=0 in READ, MODIFY, RESP.
REQ-028 csr_write SHALL never assert outside MODIFY; csr_wraddr equals latched addr whenever csr_write=1.

Reset
REQ-029 Reset SHALL asynchronously force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_write=0, csr_wraddr=0, csr_wrval=0, csr_rdaddr=0.
REQ-030 Reset asserted in READ or MODIFY SHALL abort the request with no CSR write and no response.

Configuration
REQ-031 Macro CSR_RO_CHECK_EN defined: a write-enabled request with addr[11:10]==2'b11 SHALL suppress csr_write and return resp_illegal=1 with resp_rdata = value read.
REQ-032 CSR_RO_CHECK_EN undefined: no address check; such writes proceed and resp_illegal depends only on funct3.

Verification
REQ-033 CSR 0x340 holds 0x0000_00F0; CSRRS rs1_val=0x0F, rs1_zero=0 -> resp_rdata 0xF0, write 0x340<=0xFF, resp_valid 3 cycles after accept.
REQ-034 CSR 0x340=0xFF; CSRRCI zimm=0x0F -> resp_rdata 0xFF, write 0xF0; CSRRSI zimm=0 -> resp_rdata 0xF0, csr_write never asserted.
REQ-035 funct3=100 -> resp_illegal=1, resp_rdata=0, no csr_write, resp_valid 1 cycle after accept.
REQ-036 resp_ready held low 5 cycles in RESP -> outputs stable, req_ready=0 throughout; IDLE the cycle after handshake.
REQ-037 Reset pulsed in MODIFY of CSRRW 0x305<=0x1234 -> csr_write drops immediately, CSR unchanged, resp_valid=0, req_ready=1.
REQ-038 CSRRW to 0xC00: with CSR_RO_CHECK_EN -> resp_illegal=1, no write; without -> write performed, resp_illegal=0.
